// File: rtl/instr_stream_encoder.sv
// Packs mnemonic-plus-field records into 32-bit MIPS words and emits each with a
// sequential byte address, one word per cycle under valid/ready, for COUNT words per run.
module instr_stream_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic              in_fire;
  logic              out_fire;
  logic              mnem_ok;
  logic [31:0]       enc_p0;

  function automatic logic [5:0] funct_of(input logic [4:0] m);
    case (m)
      5'd0:    funct_of = 6'h00;
      5'd1:    funct_of = 6'h02;
      5'd2:    funct_of = 6'h03;
      5'd3:    funct_of = 6'h08;
      5'd4:    funct_of = 6'h0C;
      5'd5:    funct_of = 6'h20;
      5'd6:    funct_of = 6'h21;
      5'd7:    funct_of = 6'h22;
      5'd8:    funct_of = 6'h23;
      5'd9:    funct_of = 6'h24;
      5'd10:   funct_of = 6'h25;
      5'd11:   funct_of = 6'h26;
      5'd12:   funct_of = 6'h27;
      5'd13:   funct_of = 6'h2A;
      5'd14:   funct_of = 6'h2B;
      default: funct_of = 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input logic [4:0] m);
    case (m)
      5'd15:   opcode_of = 6'h01;
      5'd16:   opcode_of = 6'h02;
      5'd17:   opcode_of = 6'h03;
      5'd18:   opcode_of = 6'h04;
      5'd19:   opcode_of = 6'h05;
      5'd20:   opcode_of = 6'h08;
      5'd21:   opcode_of = 6'h09;
      5'd22:   opcode_of = 6'h0A;
      5'd23:   opcode_of = 6'h0C;
      5'd24:   opcode_of = 6'h0D;
      5'd25:   opcode_of = 6'h23;
      5'd26:   opcode_of = 6'h29;
      5'd27:   opcode_of = 6'h2B;
      default: opcode_of = 6'h00;
    endcase
  endfunction

  // Field forcing: shifts drop rs, ALU ops drop shamt, jr keeps only rs.
  function automatic logic [31:0] encode(input logic [4:0] m, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [25:0] imm);
    logic [5:0]  fn;
    logic [5:0]  op;
    logic [31:0] w;
    fn = funct_of(m);
    op = opcode_of(m);
    case (m) inside
      [5'd0:5'd2]:   w = {6'h00, 5'd0, rt, rd, sh, fn};
      5'd3:          w = {6'h00, rs, 15'd0, fn};
      5'd4:          w = 32'h0000000C;
      [5'd5:5'd14]:  w = {6'h00, rs, rt, rd, 5'd0, fn};
      5'd15:         w = {op, rs, 5'd0, imm[15:0]};
      5'd16, 5'd17:  w = {op, imm};
      [5'd18:5'd27]: w = {op, rs, rt, imm[15:0]};
      default:       w = 32'h0;
    endcase
    return w;
  endfunction

  assign mnem_ok  = (in_mnem < 5'd28);
  assign out_fire = out_valid && out_ready;
  assign in_ready = (state == RUN) && (!out_valid || out_ready) && (rem != '0);
  assign in_fire  = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign enc_p0   = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm);

  // p0 -> output register: encoded word lands one cycle after the input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_fire && mnem_ok) begin
        out_valid <= 1'b1;
        out_instr <= enc_p0;
        out_addr  <= addr;
        addr      <= addr + ADDR_W'(4);
        rem       <= rem - CNT_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (in_fire && !mnem_ok)
        err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          addr <= base_addr;
          rem  <= count;
          err  <= 1'b0;
          if (count != '0) begin
            state <= RUN;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        RUN: if (in_fire && mnem_ok && rem == CNT_W'(1))
          state <= DRAIN;
        DRAIN: if (!out_valid || out_fire) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized and directed bench for instr_stream_encoder against a field-arithmetic
// reference model of the MIPS encodings and the run/address rules.
module tb_instr_stream_encoder;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [25:0]       in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              busy, done, err;

  always #5 clk = ~clk;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [4:0]  m, rs, rt, rd, sh;
    logic [25:0] imm;
  } rec_t;

  localparam int FUNCT [0:14]  = '{0, 2, 3, 8, 12, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  localparam int OPC   [15:27] = '{1, 2, 3, 4, 5, 8, 9, 10, 12, 13, 35, 41, 43};

  rec_t        recs[$];
  logic [31:0] got_instr[$], got_addr[$], exp_instr[$], exp_addr[$];
  int          got_cyc[$];
  int          done_cnt, done_cyc, stall_bad;
  logic        exp_err;
  int          checks = 0;
  int          errors = 0;

  function automatic rec_t mk(int m, int rs, int rt, int rd, int sh, int imm);
    rec_t r;
    r.m = 5'(m); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.sh = 5'(sh); r.imm = 26'(imm);
    return r;
  endfunction

  // Word assembled from the field positions of each instruction format.
  function automatic logic [31:0] model_word(rec_t r);
    int m;
    logic [31:0] rs, rt, rd, sh, i16, i26;
    m = int'(r.m);
    rs = 32'(r.rs) << 21; rt = 32'(r.rt) << 16; rd = 32'(r.rd) << 11; sh = 32'(r.sh) << 6;
    i16 = 32'(r.imm) & 32'h0000FFFF; i26 = 32'(r.imm);
    if (m <= 2)       return rt | rd | sh | 32'(FUNCT[m]);
    else if (m == 3)  return rs | 32'(FUNCT[m]);
    else if (m == 4)  return 32'h0000000C;
    else if (m <= 14) return rs | rt | rd | 32'(FUNCT[m]);
    else if (m == 15) return (32'(OPC[m]) << 26) | rs | i16;
    else if (m <= 17) return (32'(OPC[m]) << 26) | i26;
    else              return (32'(OPC[m]) << 26) | rs | rt | i16;
  endfunction

  task automatic build_expected(input logic [31:0] base, input int cnt);
    int k = 0;
    exp_instr.delete(); exp_addr.delete(); exp_err = 1'b0;
    foreach (recs[i]) begin
      if (k == cnt) break;
      if (recs[i].m >= 28) exp_err = 1'b1;
      else begin
        exp_instr.push_back(model_word(recs[i]));
        exp_addr.push_back(base + 32'(4 * k));
        k++;
      end
    end
  endtask

  // mode 0: out_ready=1; 1: hold out_ready low 5 cycles on the first word; 2: random out_ready
  task automatic do_run(input logic [31:0] base, input int cnt, input int mode);
    int idx = 0, stalls = 0;
    logic [31:0] hold_i = '0, hold_a = '0;
    got_instr.delete(); got_addr.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_bad = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = CNT_W'(cnt);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) start = 1'b0;
      in_valid = (idx < recs.size());
      if (in_valid) begin
        in_mnem = recs[idx].m; in_rs = recs[idx].rs; in_rt = recs[idx].rt;
        in_rd = recs[idx].rd; in_shamt = recs[idx].sh; in_imm = recs[idx].imm;
      end
      case (mode)
        1:       out_ready = !(out_valid && stalls < 5);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (mode == 1 && !out_ready) begin
        if (stalls == 0) begin hold_i = out_instr; hold_a = out_addr; end
        stalls++;
      end
      @(negedge clk);
      if (mode == 1 && !out_ready &&
          (out_instr !== hold_i || out_addr !== hold_a || in_ready !== 1'b0)) stall_bad++;
      if (out_valid && out_ready) begin
        got_instr.push_back(out_instr); got_addr.push_back(out_addr); got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) idx++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err, out_instr, out_addr} !== '0) begin
      errors++; $display("FAIL reset_hold: got %h want 0", {in_ready, out_valid, busy, done, err, out_instr, out_addr});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_release: got %b want 00000", {in_ready, out_valid, busy, done, err});
    end
  endtask

  task automatic test_basic;
    logic [31:0] wi[3] = '{32'h00221820, 32'h20010005, 32'h00011100};
    recs = '{mk(5, 1, 2, 3, 0, 0), mk(20, 0, 1, 0, 0, 5), mk(0, 7, 1, 2, 4, 0)};
    do_run(32'h0, 3, 0);
    checks++;
    if (got_instr.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", got_instr.size()); end
    foreach (got_instr[i]) if (i < 3) begin
      checks++;
      if (got_instr[i] !== wi[i] || got_addr[i] !== 32'(4 * i) || got_cyc[i] != 2 + i) begin
        errors++;
        $display("FAIL basic_word%0d: got %h@%h cyc%0d want %h@%h cyc%0d", i, got_instr[i], got_addr[i], got_cyc[i], wi[i], 4 * i, 2 + i);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 5 || err !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done_cnt %0d cyc %0d err %b want 1 5 0", done_cnt, done_cyc, err);
    end
  endtask

  task automatic test_jump_load;
    recs = '{mk(16, 0, 0, 0, 0, 26'h0100000), mk(25, 29, 4, 0, 0, 8)};
    do_run(32'h1000, 2, 0);
    checks++;
    if (got_instr.size() != 2 || got_instr[0] !== 32'h08100000 || got_addr[0] !== 32'h1000 ||
        got_instr[1] !== 32'h8FA40008 || got_addr[1] !== 32'h1004 || done_cnt != 1) begin
      errors++; $display("FAIL jump_load: got %p @ %p done %0d want 08100000,8fa40008 @ 1000,1004 done 1", got_instr, got_addr, done_cnt);
    end
    recs = '{mk(15, 5, 0, 0, 0, 16'hFFFF)};
    do_run(32'h2000, 1, 0);
    checks++;
    if (got_instr.size() != 1 || got_instr[0] !== 32'h04A0FFFF || got_addr[0] !== 32'h2000 || done_cnt != 1) begin
      errors++; $display("FAIL bltz: got %p @ %p done %0d want 04a0ffff @ 2000 done 1", got_instr, got_addr, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    recs = '{mk(5, 1, 2, 3, 0, 0), mk(7, 4, 5, 6, 0, 0)};
    build_expected(32'h300, 2);
    do_run(32'h300, 2, 1);
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_bad); end
    checks++;
    if (got_instr.size() != 2 || got_cyc[0] != 7 || got_cyc[1] != 8 || done_cnt != 1) begin
      errors++; $display("FAIL bp_timing: got %0d words cyc %p done %0d want 2 words cyc 7,8 done 1", got_instr.size(), got_cyc, done_cnt);
    end
    foreach (exp_instr[i]) if (i < got_instr.size()) begin
      checks++;
      if (got_instr[i] !== exp_instr[i] || got_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, got_instr[i], got_addr[i], exp_instr[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_invalid;
    recs = '{mk(30, 1, 2, 3, 4, 5), mk(4, 9, 9, 9, 9, 9)};
    do_run(32'h40, 1, 0);
    checks++;
    if (got_instr.size() != 1 || got_instr[0] !== 32'h0000000C || got_addr[0] !== 32'h40 ||
        err !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL invalid: got %p @ %p err %b done %0d want 0000000c @ 40 err 1 done 1", got_instr, got_addr, err, done_cnt);
    end
  endtask

  task automatic test_wrap;
    recs = '{mk(24, 3, 4, 0, 0, 16'h1234), mk(24, 5, 6, 0, 0, 16'hABCD)};
    do_run(32'hFFFFFFFC, 2, 0);
    checks++;
    if (got_instr.size() != 2 || got_addr[0] !== 32'hFFFFFFFC || got_addr[1] !== 32'h0 ||
        got_instr[0] !== 32'h34641234 || got_instr[1] !== 32'h34A6ABCD) begin
      errors++; $display("FAIL wrap: got %p @ %p want 34641234,34a6abcd @ fffffffc,0", got_instr, got_addr);
    end
  endtask

  task automatic test_random;
    for (int run = 0; run < 25; run++) begin
      int cnt, nvalid, mode;
      logic [31:0] base;
      cnt = $urandom_range(1, 6); mode = $urandom_range(0, 2); base = $urandom;
      recs.delete(); nvalid = 0;
      while (nvalid < cnt + 2) begin
        rec_t r;
        r = mk($urandom_range(0, 31), $urandom, $urandom, $urandom, $urandom, $urandom);
        if (r.m < 28) nvalid++;
        recs.push_back(r);
      end
      build_expected(base, cnt);
      do_run(base, cnt, mode);
      checks++;
      if (got_instr.size() != exp_instr.size() || done_cnt != 1 || err !== exp_err) begin
        errors++;
        $display("FAIL rand%0d_run: got %0d words done %0d err %b want %0d words done 1 err %b", run, got_instr.size(), done_cnt, err, exp_instr.size(), exp_err);
      end
      foreach (exp_instr[i]) if (i < got_instr.size()) begin
        checks++;
        if (got_instr[i] !== exp_instr[i] || got_addr[i] !== exp_addr[i]) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", run, i, got_instr[i], got_addr[i], exp_instr[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_midrun_reset;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h100; count = CNT_W'(4); out_ready = 1'b0;
    in_valid = 1'b1; in_mnem = 5'd31;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_mnem = 5'd5; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    @(posedge clk); #1;
    checks++;
    if ({busy, out_valid, err} !== 3'b111) begin
      errors++; $display("FAIL midrun_pre: got busy/out_valid/err %b want 111", {busy, out_valid, err});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err, out_instr, out_addr} !== '0) begin
      errors++; $display("FAIL midrun_reset: got %h want 0", {in_ready, out_valid, busy, done, err, out_instr, out_addr});
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    recs.delete();
    do_run(32'h500, 0, 0);
    checks++;
    if (got_instr.size() != 0 || done_cnt != 1 || done_cyc != 1) begin
      errors++; $display("FAIL count_zero: got %0d words done %0d at cyc %0d want 0 words done 1 at cyc 1", got_instr.size(), done_cnt, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump_load();
    test_backpressure();
    test_invalid();
    test_wrap();
    test_random();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoder side of the 28-instruction control decoder: it packs compact mnemonic-plus-field records into 32-bit MIPS machine words.
- Emits each word with a sequential byte address for loading instruction memory (boot/program loader path ahead of the pipeline CPU).
- One record accepted and one word produced per cycle under valid/ready flow control; a run of COUNT words is bounded by a start/done FSM.

Parameters:
- ADDR_W, 32, width of out_addr and base_addr; address arithmetic wraps mod 2^ADDR_W.
- CNT_W, 16, width of the count input and the remaining-words counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word; latched on start.
- count  in  CNT_W  number of valid words in the run; latched on start.
- in_valid  in  1  input record valid.
- in_ready  out  1  input record accepted when in_valid&&in_ready.
- in_mnem  in  5  mnemonic ID: 0 sll, 1 srl, 2 sra, 3 jr, 4 syscall, 5 add, 6 addu, 7 sub, 8 subu, 9 and, 10 or, 11 xor, 12 nor, 13 slt, 14 sltu, 15 bltz, 16 j, 17 jal, 18 beq, 19 bne, 20 addi, 21 addiu, 22 slti, 23 andi, 24 ori, 25 lw, 26 sh, 27 sw; 28-31 invalid.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  26  imm16 in [15:0]; jump target in [25:0].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  sticky: an invalid mnemonic was seen in the current run.

Behaviour:
- Reset (asynchronous, any state, including mid-run): state=IDLE; in_ready=0, out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err=0; internal address and remaining counters =0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start, latch addr=base_addr and rem=count, clear err. Go to RUN if count!=0, else to DONE.
- RUN:
  - in_ready = (!out_valid || out_ready) && rem!=0.
  - On accept with a valid mnemonic: next cycle out_valid=1, out_instr=encoding, out_addr=addr; addr+=4 (wraps); rem-=1.
  - On accept with mnemonic 28-31: record is consumed, no word emitted, err=1, addr and rem unchanged.
  - When rem reaches 0, go to DRAIN.
- DRAIN: in_ready=0. When out_valid==0, or out_valid&&out_ready, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. err holds until the next start.
- start is ignored outside IDLE.
- Latency: 1 cycle from input handshake to out_valid. Full throughput (1 word/cycle) while out_ready=1.
- While out_valid&&!out_ready: out_instr and out_addr are held stable. out_valid deasserts only after a handshake with no new record accepted in the same cycle.
- A simultaneous output handshake and input accept replaces the output register in the same edge (no bubble).
- Encoding formats:
  - R-type {000000,rs,rt,rd,shamt,funct}. Funct: sll 00, srl 02, sra 03, jr 08, syscall 0C, add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B (hex).
  - Shifts force rs=0.
  - add..sltu force shamt=0.
  - jr forces rt=rd=shamt=0.
  - syscall is the constant 0x0000000C.
  - bltz: {000001,rs,00000,imm[15:0]}.
  - j/jal: {op,imm[25:0]} with op 02/03.
  - I-type {op,rs,rt,imm[15:0]} with op: beq 04, bne 05, addi 08, addiu 09, slti 0A, andi 0C, ori 0D, lw 23, sh 29, sw 2B (hex).

Test Plan:
- start base_addr=0x00000000, count=3; records add rs1 rt2 rd3, addi rs0 rt1 imm5, sll rs7 rt1 rd2 shamt4; out_ready=1 -> words 0x00221820@0x0, 0x20010005@0x4, 0x00011100@0x8 on consecutive cycles; done pulses once; err=0.
- count=2: j imm=0x0100000, then lw rs29 rt4 imm8 -> 0x08100000, 0x8FA40008; then bltz rs5 imm=0xFFFF in a new run with count=1 -> 0x04A0FFFF.
- count=2; out_ready held 0 for 5 cycles after the first word -> out_instr and out_addr stable, in_ready=0; release -> second word follows with no loss or duplication.
- count=1; mnem=30 then syscall -> err=1, a single word 0x0000000C@base_addr, done pulses.
- base_addr=0xFFFFFFFC, count=2, two ori records -> addresses 0xFFFFFFFC then 0x00000000.
- rst asserted mid-run with out_valid=1 -> all outputs 0 immediately; next start with count=0 -> done pulse after 1 cycle and no words emitted.
